r_resp_reorder: RTL and testbench

R_RESP_REORDER -- requirements
Module: r_resp_reorder

---
 rtl/rob_pkg.sv | 19 +
 rtl/col_order_fifo.sv | 61 ++++++
 rtl/r_resp_reorder.sv | 167 ++++++++++++++++
 tb/tb_r_resp_reorder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the R-channel reorder buffer: index-width helpers and the stored beat.
package rob_pkg;

  localparam int unsigned DataWidth = 32;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned uid_w(input int unsigned rows, input int unsigned cols);
    return idx_w(rows) + idx_w(cols);
  endfunction

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
  } r_beat_t;

endpackage

// File: rtl/col_order_fifo.sv
// Per-row issue-order FIFO of column indices; pointers wrap modulo Depth.
module col_order_fifo
  import rob_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = idx_w(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  // A same-cycle pop frees the entry that a push into a full FIFO needs.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/r_resp_reorder.sv
// Restores per-row issue order of renamed single-beat AXI R responses and the original IDs.
module r_resp_reorder
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned NUM_COLS   = 4,
  parameter int unsigned DATA_WIDTH = DataWidth,
  localparam int unsigned UID_W     = uid_w(NUM_ROWS, NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid_i,
  input  logic [UID_W-1:0]      alloc_uid_i,
  input  logic [ID_WIDTH-1:0]   alloc_orig_id_i,
  input  logic                  s_rvalid_i,
  output logic                  s_rready_o,
  input  logic [UID_W-1:0]      s_rid_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic [1:0]            s_rresp_i,
  output logic                  m_rvalid_o,
  input  logic                  m_rready_i,
  output logic [ID_WIDTH-1:0]   m_rid_o,
  output logic [DATA_WIDTH-1:0] m_rdata_o,
  output logic [1:0]            m_rresp_o,
  output logic                  m_rlast_o,
  output logic                  free_req_o,
  output logic [UID_W-1:0]      free_uid_o,
  output logic                  err_unexpected_o
);

  localparam int unsigned ROW_W = idx_w(NUM_ROWS);
  localparam int unsigned COL_W = idx_w(NUM_COLS);

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alloc_q, alloc_d, valid_q, valid_d;
  logic [ID_WIDTH-1:0] tag_q  [NUM_ROWS][NUM_COLS];
  r_beat_t             slot_q [NUM_ROWS][NUM_COLS];

  logic [COL_W-1:0]    head [NUM_ROWS];
  logic [NUM_ROWS-1:0] fifo_full, fifo_empty, push, pop, deliverable;

  logic [ROW_W-1:0] a_row, s_row, sel_row, rr_q, rr_d;
  logic [COL_W-1:0] a_col, s_col, sel_col;
  logic             found, load_en, load_ok, alloc_ok, s_hs, resp_ok, err_d;

  logic                  m_valid_q, err_q;
  logic [ID_WIDTH-1:0]   m_id_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [1:0]            m_resp_q;
  logic [UID_W-1:0]      m_uid_q;

  assign a_row = alloc_uid_i[UID_W-1 -: ROW_W];
  assign a_col = alloc_uid_i[COL_W-1:0];
  assign s_row = s_rid_i[UID_W-1 -: ROW_W];
  assign s_col = s_rid_i[COL_W-1:0];

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign push[r]        = alloc_valid_i && (a_row == ROW_W'(r));
    assign pop[r]         = load_ok && (sel_row == ROW_W'(r));
    assign deliverable[r] = !fifo_empty[r] && valid_q[r][head[r]];

    col_order_fifo #(
      .Depth (NUM_COLS),
      .Width (COL_W)
    ) u_order (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[r]),
      .push_data_i (a_col),
      .pop_i       (pop[r]),
      .head_o      (head[r]),
      .full_o      (fifo_full[r]),
      .empty_o     (fifo_empty[r])
    );
  end

  // Round-robin search starting at the row after the last one served.
  always_comb begin
    int idx;
    found   = 1'b0;
    sel_row = '0;
    for (int i = 0; i < int'(NUM_ROWS); i++) begin
      idx = (int'(rr_q) + i) % int'(NUM_ROWS);
      if (!found && deliverable[idx]) begin
        found   = 1'b1;
        sel_row = ROW_W'(idx);
      end
    end
  end

  assign sel_col  = head[sel_row];
  assign load_en  = !m_valid_q || m_rready_i;
  assign load_ok  = load_en && found;
  assign alloc_ok = alloc_valid_i && (!fifo_full[a_row] || pop[a_row]);
  assign s_hs     = s_rvalid_i && s_rready_o;
  // A slot allocated this very cycle is not yet marked, so its response counts as unexpected.
  assign resp_ok  = s_hs && alloc_q[s_row][s_col] && !valid_q[s_row][s_col];
  assign err_d    = (s_hs && !resp_ok) || (alloc_valid_i && !alloc_ok);

  always_comb begin
    alloc_d = alloc_q;
    valid_d = valid_q;
    if (load_ok) begin
      alloc_d[sel_row][sel_col] = 1'b0;
      valid_d[sel_row][sel_col] = 1'b0;
    end
    if (alloc_ok) begin
      alloc_d[a_row][a_col] = 1'b1;
    end
    if (resp_ok) begin
      valid_d[s_row][s_col] = 1'b1;
    end
    rr_d = rr_q;
    if (load_ok) begin
      rr_d = (sel_row == ROW_W'(NUM_ROWS - 1)) ? '0 : sel_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q   <= '0;
      valid_q   <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_id_q    <= '0;
      m_data_q  <= '0;
      m_resp_q  <= '0;
      m_uid_q   <= '0;
    end else begin
      alloc_q <= alloc_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      if (load_en) begin
        m_valid_q <= found;
      end
      if (load_ok) begin
        m_id_q   <= tag_q[sel_row][sel_col];
        m_data_q <= DATA_WIDTH'(slot_q[sel_row][sel_col].data);
        m_resp_q <= slot_q[sel_row][sel_col].resp;
        m_uid_q  <= {sel_row, sel_col};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      tag_q[a_row][a_col] <= alloc_orig_id_i;
    end
    if (resp_ok) begin
      slot_q[s_row][s_col].data <= DataWidth'(s_rdata_i);
      slot_q[s_row][s_col].resp <= s_rresp_i;
    end
  end

  assign s_rready_o       = !rst;
  assign m_rvalid_o       = m_valid_q;
  assign m_rid_o          = m_id_q;
  assign m_rdata_o        = m_data_q;
  assign m_rresp_o        = m_resp_q;
  assign m_rlast_o        = m_valid_q;
  assign free_req_o       = m_valid_q && m_rready_i;
  assign free_uid_o       = m_uid_q;
  assign err_unexpected_o = err_q;

endmodule

// File: tb/tb_r_resp_reorder.sv
// Directed bench for r_resp_reorder with a 4x4 rename matrix.
module tb_r_resp_reorder;

  logic        clk, rst;
  logic        alloc_valid;
  logic [3:0]  alloc_uid, alloc_orig_id;
  logic        s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        m_rvalid, m_rready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, free_req;
  logic [3:0]  free_uid;
  logic        err_unexpected;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int rlast_bad = 0;
  logic [3:0]  got_id   [$];
  logic [31:0] got_data [$];
  logic [1:0]  got_resp [$];
  logic [3:0]  got_free [$];

  r_resp_reorder #(
    .ID_WIDTH   (4),
    .NUM_ROWS   (4),
    .NUM_COLS   (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid_i    (alloc_valid),
    .alloc_uid_i      (alloc_uid),
    .alloc_orig_id_i  (alloc_orig_id),
    .s_rvalid_i       (s_rvalid),
    .s_rready_o       (s_rready),
    .s_rid_i          (s_rid),
    .s_rdata_i        (s_rdata),
    .s_rresp_i        (s_rresp),
    .m_rvalid_o       (m_rvalid),
    .m_rready_i       (m_rready),
    .m_rid_o          (m_rid),
    .m_rdata_o        (m_rdata),
    .m_rresp_o        (m_rresp),
    .m_rlast_o        (m_rlast),
    .free_req_o       (free_req),
    .free_uid_o       (free_uid),
    .err_unexpected_o (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_rvalid && m_rready) begin
        got_id.push_back(m_rid);
        got_data.push_back(m_rdata);
        got_resp.push_back(m_rresp);
      end
      if (free_req) got_free.push_back(free_uid);
      if (err_unexpected) err_cnt++;
      if (m_rvalid && !m_rlast) rlast_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic alloc(input logic [3:0] uid, input logic [3:0] id);
    alloc_valid = 1'b1; alloc_uid = uid; alloc_orig_id = id;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic resp(input logic [3:0] uid, input logic [31:0] data, input logic [1:0] rr);
    s_rvalid = 1'b1; s_rid = uid; s_rdata = data; s_rresp = rr;
    tick();
    s_rvalid = 1'b0;
  endtask

  task automatic clear_q();
    got_id.delete(); got_data.delete(); got_resp.delete(); got_free.delete();
    err_cnt = 0;
  endtask

  function automatic logic [3:0] id_at(input int i);
    return (i < got_id.size()) ? got_id[i] : 4'hx;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hx;
  endfunction

  function automatic logic [3:0] free_at(input int i);
    return (i < got_free.size()) ? got_free[i] : 4'hx;
  endfunction

  initial begin
    logic [3:0]  snap_id;
    logic [31:0] snap_data;
    int          unstable;

    rst = 1'b1; alloc_valid = 1'b0; alloc_uid = '0; alloc_orig_id = '0;
    s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; m_rready = 1'b1;
    ticks(3);
    check("rst_s_rready", s_rready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_m_rid", m_rid, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_m_rlast", m_rlast, 0);
    check("rst_free_req", free_req, 0);
    check("rst_err", err_unexpected, 0);
    rst = 1'b0;
    tick();
    check("s_rready_up", s_rready, 1);

    // Same-row reversal: data for 0x0 must leave first.
    clear_q();
    alloc(4'h0, 4'h5);
    alloc(4'h1, 4'h5);
    resp(4'h1, 32'hA000_0001, 2'b00);
    resp(4'h0, 32'hA000_0000, 2'b10);
    ticks(4);
    check("t1_count", got_id.size(), 2);
    check("t1_id0", id_at(0), 4'h5);
    check("t1_data0", data_at(0), 32'hA000_0000);
    check("t1_resp0", (got_resp.size() > 0) ? got_resp[0] : 2'bxx, 2'b10);
    check("t1_id1", id_at(1), 4'h5);
    check("t1_data1", data_at(1), 32'hA000_0001);
    check("t1_free0", free_at(0), 4'h0);
    check("t1_free1", free_at(1), 4'h1);
    check("t1_err", err_cnt, 0);

    // Different rows do not block one another.
    clear_q();
    alloc(4'h0, 4'h3);
    alloc(4'h4, 4'h7);
    resp(4'h4, 32'hB000_0004, 2'b00);
    ticks(3);
    check("t2_count_a", got_id.size(), 1);
    check("t2_id_first", id_at(0), 4'h7);
    check("t2_free_first", free_at(0), 4'h4);
    resp(4'h0, 32'hB000_0000, 2'b00);
    ticks(3);
    check("t2_id_second", id_at(1), 4'h3);
    check("t2_data_second", data_at(1), 32'hB000_0000);

    // Backpressure with three rows deliverable.
    clear_q();
    m_rready = 1'b0;
    alloc(4'h0, 4'h1);
    alloc(4'h4, 4'h2);
    alloc(4'h8, 4'h4);
    resp(4'h0, 32'hC000_0000, 2'b00);
    resp(4'h4, 32'hC000_0004, 2'b00);
    resp(4'h8, 32'hC000_0008, 2'b00);
    check("t3_held_valid", m_rvalid, 1);
    check("t3_held_rlast", m_rlast, 1);
    check("t3_held_id", m_rid, 4'h1);
    check("t3_held_data", m_rdata, 32'hC000_0000);
    snap_id = m_rid; snap_data = m_rdata; unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!m_rvalid || m_rid != snap_id || m_rdata != snap_data || free_req) unstable++;
    end
    check("t3_stable", unstable, 0);
    check("t3_no_free", got_free.size(), 0);
    m_rready = 1'b1;
    ticks(4);
    check("t3_count", got_id.size(), 3);
    check("t3_id0", id_at(0), 4'h1);
    check("t3_id1", id_at(1), 4'h2);
    check("t3_id2", id_at(2), 4'h4);
    check("t3_data2", data_at(2), 32'hC000_0008);
    check("t3_free1", free_at(1), 4'h4);
    check("t3_free2", free_at(2), 4'h8);

    // Unexpected response to an unallocated slot.
    clear_q();
    resp(4'h9, 32'hDEAD_BEEF, 2'b00);
    check("t4_err_pulse", err_unexpected, 1);
    tick();
    check("t4_err_drop", err_unexpected, 0);
    ticks(3);
    check("t4_err_count", err_cnt, 1);
    check("t4_no_beat", got_id.size(), 0);
    check("t4_m_rvalid", m_rvalid, 0);

    // Fill row 0, overflow it, drain, then wrap around.
    clear_q();
    m_rready = 1'b0;
    alloc(4'h0, 4'h8);
    alloc(4'h1, 4'h9);
    alloc(4'h2, 4'hA);
    alloc(4'h3, 4'hB);
    check("t5_no_err_fill", err_cnt, 0);
    alloc(4'h0, 4'hF);
    check("t5_full_err", err_unexpected, 1);
    resp(4'h3, 32'hD000_0003, 2'b00);
    resp(4'h2, 32'hD000_0002, 2'b00);
    resp(4'h1, 32'hD000_0001, 2'b00);
    resp(4'h0, 32'hD000_0000, 2'b00);
    m_rready = 1'b1;
    ticks(6);
    check("t5_count", got_id.size(), 4);
    check("t5_id0", id_at(0), 4'h8);
    check("t5_data0", data_at(0), 32'hD000_0000);
    check("t5_id3", id_at(3), 4'hB);
    check("t5_data3", data_at(3), 32'hD000_0003);
    alloc(4'h0, 4'hC);
    alloc(4'h1, 4'hD);
    resp(4'h1, 32'hE000_0001, 2'b00);
    resp(4'h0, 32'hE000_0000, 2'b00);
    ticks(4);
    check("t5_wrap_count", got_id.size(), 6);
    check("t5_wrap_id0", id_at(4), 4'hC);
    check("t5_wrap_data0", data_at(4), 32'hE000_0000);
    check("t5_wrap_id1", id_at(5), 4'hD);
    check("t5_err_total", err_cnt, 1);

    // Mid-operation reset discards held beats.
    clear_q();
    m_rready = 1'b0;
    alloc(4'h4, 4'h1);
    alloc(4'h5, 4'h2);
    alloc(4'h8, 4'h3);
    resp(4'h4, 32'hF000_0004, 2'b00);
    resp(4'h5, 32'hF000_0005, 2'b00);
    resp(4'h8, 32'hF000_0008, 2'b00);
    check("t6_pre_valid", m_rvalid, 1);
    rst = 1'b1;
    #1;
    check("t6_async_valid", m_rvalid, 0);
    check("t6_async_rid", m_rid, 0);
    check("t6_s_rready", s_rready, 0);
    ticks(2);
    rst = 1'b0;
    m_rready = 1'b1;
    ticks(5);
    check("t6_no_stale", got_id.size(), 0);
    alloc(4'h4, 4'h6);
    resp(4'h4, 32'h1234_5678, 2'b01);
    ticks(3);
    check("t6_post_count", got_id.size(), 1);
    check("t6_post_id", id_at(0), 4'h6);
    check("t6_post_data", data_at(0), 32'h1234_5678);
    check("t6_post_free", free_at(0), 4'h4);
    check("rlast_tracks_valid", rlast_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
